// File: rtl/neuron_mac_q9.sv
// neuron_mac_q9: single-neuron multiply-accumulate in Q7.9.
// Streams len (x,w) pairs into a full-precision accumulator seeded with the bias,
// then rounds half toward +inf, saturates to 16 bits and presents the result on a
// valid/ready output. All outputs come straight from flops.
module neuron_mac_q9 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC   = 9,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] w_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              sat,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAcc, StRound, StOut} state_e;

    localparam logic signed [ACC_W-1:0] RndHalf = ACC_W'(1) << (FRAC - 1);

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         len_q, len_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     sat_q, sat_d;
    logic                     out_valid_q, out_valid_d;
    logic                     in_ready_q, in_ready_d;
    logic                     busy_q, busy_d;

    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    rnd_shift;
    logic [ACC_W-DATA_W:0]      rnd_hi;
    logic                       clip;
    logic [DATA_W-1:0]          rnd_sat;
    logic                       accept;

    // Datapath: bias alignment, product, rounding and saturation
    always_comb begin
        bias_ext  = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC;
        prod      = $signed(x_in) * $signed(w_in);
        prod_ext  = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        rnd_shift = (acc_q + RndHalf) >>> FRAC;
        // Result fits iff every bit above the 16-bit sign position matches the sign
        rnd_hi    = rnd_shift[ACC_W-1:DATA_W-1];
        clip      = !((&rnd_hi) || !(|rnd_hi));
        if (!clip) begin
            rnd_sat = rnd_shift[DATA_W-1:0];
        end else if (rnd_shift[ACC_W-1]) begin
            rnd_sat = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            rnd_sat = {1'b0, {(DATA_W-1){1'b1}}};
        end
        accept = in_valid && in_ready_q;
    end

    // Next-state logic; handshake outputs are decoded from the next state so they register
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        out_data_d = out_data_q;
        sat_d      = sat_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = bias_ext;
                    cnt_d   = '0;
                    len_d   = len;
                    state_d = (len != '0) ? StAcc : StRound;
                end
            end
            StAcc: begin
                if (accept) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        state_d = StRound;
                    end
                end
            end
            StRound: begin
                out_data_d = rnd_sat;
                sat_d      = clip;
                state_d    = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d  = (state_d == StAcc);
        out_valid_d = (state_d == StOut);
        busy_d      = (state_d != StIdle);
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat       = sat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_mac_q9.sv
// Directed bench for neuron_mac_q9: drives at posedge+1, observes at posedge+1.
module tb_neuron_mac_q9;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [15:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic [15:0] w_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        sat;
    logic        busy;

    int errors = 0;
    int checks = 0;

    neuron_mac_q9 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .w_in      (w_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat       (sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start pulse; returns one edge later
    task automatic do_start(input logic [7:0] l, input logic [15:0] b);
        start = 1'b1;
        len   = l;
        bias  = b;
        step();
        start = 1'b0;
        len   = 8'hAA;
        bias  = 16'h5A5A;
    endtask

    // Present one pair, optionally after idle gap cycles, and return after its accept edge
    task automatic feed(input logic [15:0] x, input logic [15:0] w, input int gap);
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) step();
        for (int i = 0; i < 20 && !in_ready; i++) step();
        check("in_ready_before_pair", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        x_in     = x;
        w_in     = w;
        step();
        in_valid = 1'b0;
        x_in     = 16'hDEAD;
        w_in     = 16'hBEEF;
    endtask

    // Called right after the last accept (or start for len 0): result appears one edge later
    task automatic expect_out(input string tag, input logic [15:0] d, input logic s);
        check({tag, "_no_early_valid"}, {31'd0, out_valid}, 32'd0);
        step();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, {16'd0, out_data}, {16'd0, d});
        check({tag, "_sat"}, {31'd0, sat}, {31'd0, s});
        check({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        bias      = '0;
        in_valid  = 1'b0;
        x_in      = '0;
        w_in      = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_sat", {31'd0, sat}, 32'd0);
        rst = 1'b0;
        step();

        // 1: 1.0 * 1.0 = 1.0
        do_start(8'd1, 16'h0000);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);
        feed(16'h0200, 16'h0200, 0);
        expect_out("t1", 16'h0200, 1'b0);

        // 2: 0.5 + (1 + 2 - 1) * 0.5 = 1.5
        do_start(8'd3, 16'h0100);
        feed(16'h0200, 16'h0100, 0);
        feed(16'h0400, 16'h0100, 0);
        feed(16'hFE00, 16'h0100, 0);
        expect_out("t2", 16'h0300, 1'b0);

        // 3: positive and negative saturation
        do_start(8'd4, 16'h0000);
        for (int i = 0; i < 4; i++) feed(16'h7FFF, 16'h7FFF, 0);
        expect_out("t3_pos", 16'h7FFF, 1'b1);
        do_start(8'd4, 16'h0000);
        for (int i = 0; i < 4; i++) feed(16'h8000, 16'h7FFF, 0);
        expect_out("t3_neg", 16'h8000, 1'b1);

        // 4: rounding half toward +inf
        do_start(8'd1, 16'h0000);
        feed(16'h0001, 16'h0100, 0);
        expect_out("t4_up", 16'h0001, 1'b0);
        do_start(8'd1, 16'h0000);
        feed(16'hFFFF, 16'h0100, 0);
        expect_out("t4_half_neg", 16'h0000, 1'b0);

        // 5a: output backpressure with start pulses in OUT
        do_start(8'd1, 16'h0000);
        feed(16'h0200, 16'h0300, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len   = 8'd2;
            bias  = 16'h1234;
            check("t5_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t5_hold_data", {16'd0, out_data}, 32'h0300);
            check("t5_hold_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t5_release", {31'd0, out_valid}, 32'd0);
        step();
        check("t5_no_queued_job", {31'd0, busy}, 32'd0);

        // 5b: test 2 again with random input gaps
        do_start(8'd3, 16'h0100);
        feed(16'h0200, 16'h0100, int'($urandom_range(0, 4)));
        feed(16'h0400, 16'h0100, int'($urandom_range(0, 4)));
        feed(16'hFE00, 16'h0100, int'($urandom_range(0, 4)));
        expect_out("t5_gaps", 16'h0300, 1'b0);

        // 6a: empty job passes bias through
        do_start(8'd0, 16'hFF80);
        expect_out("t6_len0", 16'hFF80, 1'b0);

        // 6b: reset in the middle of accumulation
        do_start(8'd3, 16'h0100);
        feed(16'h0400, 16'h0400, 0);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_data", {16'd0, out_data}, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("t6_after_rst_valid", {31'd0, out_valid}, 32'd0);
        do_start(8'd1, 16'h0000);
        feed(16'h0200, 16'h0200, 0);
        expect_out("t6_rerun", 16'h0200, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
